// File: rtl/dpram_loader_if.sv
// Signal bundle between the ioctl download source, the clear requester and
// dpram port B, with the loader acting as slave of the download side.
interface dpram_loader_if #(
  parameter int addr_width = 8,
  parameter int data_width = 16
);
  logic                  dl_active;
  logic                  dl_wr;
  logic [7:0]            dl_data;
  logic                  dl_wait;
  logic                  clear_req;
  logic [addr_width-1:0] ram_address;
  logic [data_width-1:0] ram_data;
  logic                  ram_wren;
  logic                  ram_cs;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    output dl_active, dl_wr, dl_data, clear_req,
    input  dl_wait, ram_address, ram_data, ram_wren, ram_cs, busy, done, overflow
  );

  modport slave (
    input  dl_active, dl_wr, dl_data, clear_req,
    output dl_wait, ram_address, ram_data, ram_wren, ram_cs, busy, done, overflow
  );
endinterface

// File: rtl/dpram_loader.sv
// Packs a byte download stream into little-endian words for dpram port B and
// can clear the whole RAM to a fill pattern.
module dpram_loader #(
  parameter int                    addr_width = 8,
  parameter int                    data_width = 16,
  parameter logic [data_width-1:0] fill_value = '0,
  parameter logic [7:0]            pad_byte   = 8'h00
) (
  input  logic          clock,
  input  logic          reset,
  dpram_loader_if.slave bus
);
  localparam int BPW = data_width / 8;
  localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LW-1:0]         LAST_LANE = LW'(BPW - 1);
  localparam logic [addr_width-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, FILL, LOAD, FLUSH} state_t;

  state_t                state_q, state_d;
  logic                  act_q;
  logic                  pend_q, pend_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [addr_width:0]   wa_q, wa_d;
  logic [data_width-1:0] pack_q, pack_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  wren_q, wren_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic rise, take, full, fill_last;

  function automatic logic [data_width-1:0] put_lane(input logic [data_width-1:0] w,
                                                     input logic [LW-1:0] l,
                                                     input logic [7:0] b);
    logic [data_width-1:0] r;
    r = w;
    for (int i = 0; i < BPW; i++)
      if (l == LW'(i)) r[8*i +: 8] = b;
    return r;
  endfunction

  function automatic logic [data_width-1:0] pad_from(input logic [data_width-1:0] w,
                                                     input logic [LW-1:0] l);
    logic [data_width-1:0] r;
    r = w;
    for (int i = 0; i < BPW; i++)
      if (i >= int'(l)) r[8*i +: 8] = pad_byte;
    return r;
  endfunction

  // The extra top bit of the word address marks "RAM full" so it never wraps.
  assign rise      = bus.dl_active & ~act_q;
  assign full      = wa_q[addr_width];
  assign take      = (state_q == LOAD) & bus.dl_active & bus.dl_wr;
  assign fill_last = (state_q == FILL) & (addr_q == LAST_ADDR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      act_q   <= 1'b0;
      pend_q  <= 1'b0;
      lane_q  <= '0;
      wa_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= bus.dl_active;
      pend_q  <= pend_d;
      lane_q  <= lane_d;
      wa_q    <= wa_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    pack_q <= pack_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.clear_req) state_d = FILL;
               else if (rise)     state_d = LOAD;
      FILL:    if (fill_last)     state_d = (pend_q || rise) ? LOAD : IDLE;
      LOAD:    if (!bus.dl_active) state_d = (lane_q == '0) ? IDLE : FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write port registers are loaded one cycle ahead of the cycle they drive.
  always_comb begin
    pend_d = pend_q;
    lane_d = lane_q;
    wa_d   = wa_q;
    pack_d = pack_q;
    addr_d = addr_q;
    data_d = data_q;
    wren_d = 1'b0;
    done_d = 1'b0;
    ovf_d  = ovf_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          ovf_d  = 1'b0;
          lane_d = '0;
          wa_d   = '0;
        end
        if (bus.clear_req) begin
          pend_d = rise;
          addr_d = '0;
          data_d = fill_value;
          wren_d = 1'b1;
        end
      end
      FILL: begin
        if (rise)       ovf_d = 1'b0;
        if (bus.dl_wr)  ovf_d = 1'b1;
        if (fill_last) begin
          done_d = 1'b1;
          pend_d = 1'b0;
          lane_d = '0;
          wa_d   = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          wren_d = 1'b1;
          if (rise) pend_d = 1'b1;
        end
      end
      LOAD: begin
        if (take) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            pack_d = put_lane(pack_q, lane_q, bus.dl_data);
            if (lane_q == LAST_LANE) begin
              lane_d = '0;
              data_d = pack_d;
              addr_d = wa_q[addr_width-1:0];
              wren_d = 1'b1;
              wa_d   = wa_q + 1'b1;
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end
        end else if (!bus.dl_active) begin
          done_d = 1'b1;
          if (lane_q != '0 && !full) begin
            data_d = pad_from(pack_q, lane_q);
            addr_d = wa_q[addr_width-1:0];
            wren_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.ram_address = addr_q;
  assign bus.ram_data    = data_q;
  assign bus.ram_wren    = wren_q;
  assign bus.ram_cs      = (state_q != IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.dl_wait     = (state_q == FILL);
  assign bus.done        = done_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_dpram_loader.sv
// Scoreboard bench for dpram_loader: stimulus pushes expected RAM writes from a
// byte-stream model, a negedge monitor pops and compares every write.
module tb_dpram_loader;
  localparam int                AW    = 2;
  localparam int                DW    = 16;
  localparam int                BPW   = DW / 8;
  localparam int                DEPTH = 1 << AW;
  localparam logic [DW-1:0]     FILLV = 16'hFFFF;
  localparam logic [7:0]        PAD   = 8'h00;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [7:0] stim[$];

  dpram_loader_if #(.addr_width(AW), .data_width(DW)) bus ();

  dpram_loader #(
    .addr_width(AW),
    .data_width(DW),
    .fill_value(FILLV),
    .pad_byte  (PAD)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({bus.dl_wait, bus.ram_address, bus.ram_data, bus.ram_wren,
                     bus.ram_cs, bus.busy, bus.done, bus.overflow}), 32'(0));
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ram_wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, no write expected",
                 bus.ram_address, bus.ram_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.ram_address !== mon_e.a || bus.ram_data !== mon_e.d || bus.ram_cs !== 1'b1) begin
          errors++;
          $display("FAIL ram_write: got addr=%0d data=%h cs=%b expected addr=%0d data=%h cs=1",
                   bus.ram_address, bus.ram_data, bus.ram_cs, mon_e.a, mon_e.d);
        end
      end
    end
  end

  // Reference: bytes fill words little-endian; at most DEPTH words; last partial word padded.
  task automatic model_download(output bit ovf, output bit flush);
    int n;
    n = stim.size();
    for (int w = 0; w < DEPTH && w * BPW < n; w++) begin
      wr_t e;
      e.a = AW'(w);
      for (int k = 0; k < BPW; k++)
        e.d[8*k +: 8] = (w * BPW + k < n) ? stim[w * BPW + k] : PAD;
      exp_q.push_back(e);
    end
    ovf   = (n > DEPTH * BPW);
    flush = (n < DEPTH * BPW) && (n % BPW != 0);
  endtask

  // Called at posedge+1 with dl_active already high and the loader in LOAD.
  task automatic stream(input int maxgap, input bit inject_clear);
    bit exp_ovf, exp_flush;
    int n;
    n = stim.size();
    model_download(exp_ovf, exp_flush);
    for (int i = 0; i < n; i++) begin
      bus.dl_wr     = 1'b1;
      bus.dl_data   = stim[i];
      bus.clear_req = inject_clear && (i == n / 2);
      if (i == 0) begin
        @(negedge clk);
        check("overflow_cleared_on_start", 32'(bus.overflow), 32'(0));
      end
      @(posedge clk); #1;
      bus.dl_wr     = 1'b0;
      bus.clear_req = 1'b0;
      repeat ($urandom_range(maxgap, 0)) begin
        @(posedge clk); #1;
      end
    end
    bus.dl_active = 1'b0;
    @(negedge clk);
    check("done_not_early", 32'(bus.done), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("done_after_fall", 32'(bus.done), 32'(1));
    check("flush_write_with_done", 32'(bus.ram_wren), 32'(exp_flush));
    @(posedge clk); #1;
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'(0));
    check("busy_idle_after_load", 32'(bus.busy), 32'(0));
    check("overflow_after_load", 32'(bus.overflow), 32'(exp_ovf));
    @(posedge clk); #1;
  endtask

  task automatic start_download(input int maxgap, input bit inject_clear);
    bus.dl_active = 1'b1;
    @(posedge clk); #1;
    stream(maxgap, inject_clear);
  endtask

  // abort_after=N>0 asserts reset right after the Nth fill write.
  task automatic do_fill(input bit with_rise, input bit drop_wr, input int abort_after);
    wr_t e;
    bus.clear_req = 1'b1;
    if (with_rise) bus.dl_active = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      if (abort_after == 0 || a < abort_after) begin
        e.a = AW'(a);
        e.d = FILLV;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    bus.clear_req = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (drop_wr && k == 1) begin
        bus.dl_wr   = 1'b1;
        bus.dl_data = 8'h77;
      end
      @(negedge clk);
      check("fill_wren", 32'(bus.ram_wren), 32'(1));
      check("fill_dl_wait", 32'(bus.dl_wait), 32'(1));
      if (abort_after != 0 && k + 1 == abort_after) begin
        #1 rst = 1'b1;
        #1 check_all_zero("reset_abort_outputs");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      bus.dl_wr = 1'b0;
    end
    @(negedge clk);
    check("fill_done", 32'(bus.done), 32'(1));
    check("fill_busy_after", 32'(bus.busy), 32'(with_rise));
    check("fill_dl_wait_released", 32'(bus.dl_wait), 32'(0));
    if (drop_wr) check("fill_drop_overflow", 32'(bus.overflow), 32'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.dl_active = 1'b0;
    bus.dl_wr     = 1'b0;
    bus.dl_data   = 8'h00;
    bus.clear_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(posedge clk); #1;

    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_download(0, 1'b0);

    stim = '{8'hAA, 8'hBB, 8'hCC};
    start_download(0, 1'b0);

    do_fill(1'b0, 1'b0, 0);

    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(8'($urandom));
    start_download(0, 1'b0);

    stim = '{8'h5E};
    start_download(0, 1'b0);

    stim = '{8'h01, 8'h02, 8'h03};
    do_fill(1'b1, 1'b0, 0);
    stream(0, 1'b0);

    do_fill(1'b0, 1'b1, 0);

    for (int it = 0; it < 12; it++) begin
      int n;
      if ($urandom_range(3, 0) == 0) do_fill(1'b0, 1'b0, 0);
      n = int'($urandom_range(10, 1));
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      start_download(2, 1'($urandom_range(1, 0)));
    end

    do_fill(1'b0, 1'b0, 3);
    stim = '{8'h9A, 8'hBC};
    start_download(0, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
